// File: rtl/cic_integrator_decimator_pkg.sv
// ----------------------------------------------------------------------------
// cic_pkg
//
// Shared definitions for the CIC decimation filter. Both the integrator half
// (cic_integrator_decimator) and the differentiator half (comb chain) use it.
//
// Contents:
//   CIC_* localparams   default filter configuration
//   cic_clog2()         ceiling log2, usable in constant expressions
//   cic_acc_width()     integrator register width: in_w + stages*clog2(rate)
//   cic_sext()          sign-extends the low 'width' bits of a value to 64 bits
// ----------------------------------------------------------------------------
package cic_pkg;

    localparam int CIC_IN_WIDTH  = 8;
    localparam int CIC_STAGES    = 3;
    localparam int CIC_RATE      = 8;
    localparam int CIC_OUT_WIDTH = 17;

    // Ceiling log2; clog2(1) = 0.
    function automatic int cic_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Register growth bound of a CIC filter: every integrator stage can grow
    // the magnitude by at most a factor of RATE.
    function automatic int cic_acc_width(input int in_w, input int stages, input int rate);
        return in_w + stages * cic_clog2(rate);
    endfunction

    // Sign-extends bits [width-1:0] of value to the full 64-bit result.
    // Callers narrow the result to their register width with a size cast.
    function automatic logic [63:0] cic_sext(input logic [63:0] value, input int width);
        logic [63:0] result;
        result = value;
        for (int i = 0; i < 64; i++) begin
            if (i >= width) begin
                result[i] = value[width-1];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cic_integrator_decimator_integrator.sv
// ----------------------------------------------------------------------------
// cic_integrator
//
// One CIC integrator stage: a WIDTH-bit accumulator that adds 'addend' on
// every enabled clock. Arithmetic wraps modulo 2^WIDTH, which is exactly what
// a CIC filter needs: the comb chain cancels the wrap as long as the register
// is at least as wide as the filter's worst-case gain requires.
//
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset, clears acc
//   en      in   accumulate this cycle
//   addend  in   WIDTH  value added to acc when en=1
//   acc     out  WIDTH  registered accumulator value
// ----------------------------------------------------------------------------
module cic_integrator #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc
);

    // NOTE: the accumulator is state that must start from a known value, so
    // it sits under reset; a wrong start value would persist forever, since
    // an integrator never forgets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/cic_integrator_decimator.sv
// ----------------------------------------------------------------------------
// cic_integrator_decimator
//
// Front half of a CIC decimator: STAGES cascaded integrators running at the
// input sample rate, followed by a RATE:1 downsampler. It emits one scaled
// sample per RATE accepted inputs and a matching hold signal for the comb
// chain, so the combs advance only on decimated samples.
//
// Build option:
//   CIC_INTEG_ROUND_EN  when defined, the output scaling rounds half up
//                       (adds 2^(D-1) before dropping D LSBs). When not
//                       defined, the scaling truncates toward -inf.
//                       D = ACC_WIDTH - OUT_WIDTH; with D = 0 the option has
//                       no effect.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   data_in carries a sample this cycle
//   data_in    in   IN_WIDTH      signed input sample
//   data_out   out  OUT_WIDTH     decimated, scaled integrator output (signed)
//   out_valid  out  one-cycle pulse: data_out was updated this cycle
//   hold       out  registered ~out_valid, holds the comb stages
//   phase      out  clog2(RATE)   decimation counter
// ----------------------------------------------------------------------------
module cic_integrator_decimator
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = CIC_IN_WIDTH,
    parameter int STAGES    = CIC_STAGES,
    parameter int RATE      = CIC_RATE,
    parameter int OUT_WIDTH = CIC_OUT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [IN_WIDTH-1:0]       data_in,
    output logic [OUT_WIDTH-1:0]      data_out,
    output logic                      out_valid,
    output logic                      hold,
    output logic [$clog2(RATE)-1:0]   phase
);

    localparam int ACC_WIDTH = cic_acc_width(IN_WIDTH, STAGES, RATE);
    localparam int PH_WIDTH  = $clog2(RATE);
    localparam int D         = ACC_WIDTH - OUT_WIDTH;

`ifdef CIC_INTEG_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    // Half an output LSB, expressed in accumulator LSBs. Zero when there
    // are no discarded bits or rounding is disabled.
    localparam int RSH = (D > 0) ? D - 1 : 0;
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS =
        (ROUND_EN && (D > 0)) ? (ACC_WIDTH'(1) << RSH) : '0;

    localparam logic [PH_WIDTH-1:0] LAST_PHASE = PH_WIDTH'(RATE - 1);

    // Elaboration-time guards on the configuration.
    if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
        $error("cic_integrator_decimator: STAGES must be 1..6");
    end
    if (RATE < 2) begin : g_bad_rate
        $error("cic_integrator_decimator: RATE must be >= 2");
    end
    if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_out_width
        $error("cic_integrator_decimator: OUT_WIDTH must be <= ACC_WIDTH");
    end
    if (ACC_WIDTH > 64) begin : g_bad_acc_width
        $error("cic_integrator_decimator: ACC_WIDTH above 64 is not supported");
    end

    // ------------------------------------------------------------------
    // Integrator chain
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc    [STAGES];
    logic [ACC_WIDTH-1:0] addend [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign addend[k] = ACC_WIDTH'(cic_sext(64'(data_in), IN_WIDTH));
        end else begin : g_chain
            // Each stage adds the previous stage's registered value, so
            // all stages update together from pre-update values.
            assign addend[k] = acc[k-1];
        end

        cic_integrator #(
            .WIDTH (ACC_WIDTH)
        ) u_integrator (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (in_valid),
            .addend (addend[k]),
            .acc    (acc[k])
        );
    end

    // ------------------------------------------------------------------
    // Output scaling
    // ------------------------------------------------------------------
    // The decimated sample is the value the last integrator is about to
    // take, so out_valid lands one clock after the RATE-th sample rather
    // than two.
    logic [ACC_WIDTH-1:0] last_next;
    logic [ACC_WIDTH-1:0] last_rounded;
    logic [OUT_WIDTH-1:0] scaled;

    assign last_next    = acc[STAGES-1] + addend[STAGES-1];
    assign last_rounded = last_next + ROUND_BIAS;
    // A logical shift followed by narrowing keeps bits [ACC_WIDTH-1:D];
    // the sign bit of the result is the accumulator's sign bit.
    assign scaled       = OUT_WIDTH'(last_rounded >> D);

    // ------------------------------------------------------------------
    // Decimation counter and output register
    // ------------------------------------------------------------------
    logic frame_end;

    assign frame_end = in_valid && (phase == LAST_PHASE);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            hold      <= 1'b1;
        end else begin
            out_valid <= frame_end;
            hold      <= ~frame_end;
            if (frame_end) begin
                data_out <= scaled;
            end
            if (in_valid) begin
                phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// ----------------------------------------------------------------------------
// tb_cic_integrator_decimator
//
// Directed bench for cic_integrator_decimator. Four instances cover the
// configurations of interest; all share clk and rst_n and each has its own
// input stimulus (idle instances see in_valid=0).
//   dut_a  STAGES=1 RATE=4 OUT=10 (ACC=10): steady input, gaps, reset mid-frame
//   dut_b  STAGES=2 RATE=4 OUT=12 (ACC=12): impulse response
//   dut_c  STAGES=1 RATE=2 OUT=9  (ACC=9) : accumulator wrap-around
//   dut_d  STAGES=1 RATE=2 OUT=8  (ACC=9) : output scaling, truncate or round
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge that consumed the previous inputs.
// ----------------------------------------------------------------------------
module tb_cic_integrator_decimator;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // dut_a
    logic       va;
    logic [7:0] da;
    logic [9:0] oa;
    logic       ova, hla;
    logic [1:0] pha;
    // dut_b
    logic        vb;
    logic [7:0]  db;
    logic [11:0] ob;
    logic        ovb, hlb;
    logic [1:0]  phb;
    // dut_c
    logic       vc;
    logic [7:0] dc;
    logic [8:0] oc;
    logic       ovc, hlc;
    logic [0:0] phc;
    // dut_d
    logic       vd;
    logic [7:0] dd;
    logic [7:0] od;
    logic       ovd, hld;
    logic [0:0] phd;

    int checks = 0;
    int errors = 0;

    cic_integrator_decimator #(.IN_WIDTH(8), .STAGES(1), .RATE(4), .OUT_WIDTH(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .data_in(da),
        .data_out(oa), .out_valid(ova), .hold(hla), .phase(pha)
    );

    cic_integrator_decimator #(.IN_WIDTH(8), .STAGES(2), .RATE(4), .OUT_WIDTH(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .data_in(db),
        .data_out(ob), .out_valid(ovb), .hold(hlb), .phase(phb)
    );

    cic_integrator_decimator #(.IN_WIDTH(8), .STAGES(1), .RATE(2), .OUT_WIDTH(9)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .data_in(dc),
        .data_out(oc), .out_valid(ovc), .hold(hlc), .phase(phc)
    );

    cic_integrator_decimator #(.IN_WIDTH(8), .STAGES(1), .RATE(2), .OUT_WIDTH(8)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(vd), .data_in(dd),
        .data_out(od), .out_valid(ovd), .hold(hld), .phase(phd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Expected dut_d outputs depend on the rounding build option.
`ifdef CIC_INTEG_ROUND_EN
    localparam logic [7:0] D_EXP_FIRST  = 8'd2;   // (3+1)>>1
    localparam logic [7:0] D_EXP_SECOND = 8'h00;  // (0x1FF+1 mod 512)>>1
`else
    localparam logic [7:0] D_EXP_FIRST  = 8'd1;   // 3>>1
    localparam logic [7:0] D_EXP_SECOND = 8'hFF;  // 0x1FF>>1 = -1
`endif

    initial begin
        int cnt;
        logic [7:0] d_seq [4];

        va = 1'b0; da = '0;
        vb = 1'b0; db = '0;
        vc = 1'b0; dc = '0;
        vd = 1'b0; dd = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_data",  32'(oa),  32'd0);
        check("rst_valid", 32'(ova), 32'd0);
        check("rst_hold",  32'(hla), 32'd1);
        check("rst_phase", 32'(pha), 32'd0);

        // 1. Steady input of 1: pulses every 4th cycle carrying 4, 8, 12, 16
        va = 1'b1; da = 8'd1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t1_valid", 32'(ova), 32'(i % 4 == 0));
            check("t1_hold",  32'(hla), 32'(i % 4 != 0));
            check("t1_phase", 32'(pha), 32'(i % 4));
            if (i % 4 == 0) begin
                check("t1_data", 32'(oa), 32'(4 * (i / 4)));
            end
        end
        va = 1'b0;

        // 4. Same stream with in_valid alternating: pulses every 8 cycles,
        //    phase frozen on idle cycles, data_out held between pulses.
        do_reset();
        cnt = 0;
        for (int c = 0; c < 32; c++) begin
            va = (c % 2 == 0);
            tick();
            if (va) cnt++;
            check("t4_valid", 32'(ova), 32'(va && (cnt % 4 == 0)));
            check("t4_phase", 32'(pha), 32'(cnt % 4));
            check("t4_data",  32'(oa),  32'(4 * (cnt / 4)));
        end

        // 5. Reset mid-frame after two samples (phase=2, data_out=16)
        va = 1'b1; da = 8'd1;
        tick();
        tick();
        check("t5_pre_phase", 32'(pha), 32'd2);
        check("t5_pre_data",  32'(oa),  32'd16);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst_phase", 32'(pha), 32'd0);
        check("t5_rst_data",  32'(oa),  32'd0);
        check("t5_rst_valid", 32'(ova), 32'd0);
        check("t5_rst_hold",  32'(hla), 32'd1);
        check("t5_rst_acc",   32'(dut_a.acc[0]), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t5_valid", 32'(ova), 32'(i == 4));
        end
        check("t5_data", 32'(oa), 32'd4);
        va = 1'b0;

        // 2. Two-stage impulse response: 3 after sample 4, 7 after sample 8
        do_reset();
        vb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            db = (i == 1) ? 8'd1 : 8'd0;
            tick();
            check("t2_valid", 32'(ovb), 32'(i == 4 || i == 8));
            check("t2_hold",  32'(hlb), 32'(!(i == 4 || i == 8)));
            if (i == 4) check("t2_data_first",  32'(ob), 32'd3);
            if (i == 8) check("t2_data_second", 32'(ob), 32'd7);
        end
        vb = 1'b0;

        // 3. Wrap-around: 127 continuous into a 9-bit accumulator
        do_reset();
        vc = 1'b1; dc = 8'd127;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t3_valid", 32'(ovc), 32'(i % 2 == 0));
            if (i == 2) check("t3_data_254",  32'(oc), 32'd254);
            if (i == 4) check("t3_data_wrap", 32'(oc), 32'h1FC);
        end
        vc = 1'b0;

        // 6. Scaling by one bit: samples 1,2 (acc=3) then -2,-2 (acc=-1)
        do_reset();
        d_seq[0] = 8'd1;
        d_seq[1] = 8'd2;
        d_seq[2] = 8'hFE;
        d_seq[3] = 8'hFE;
        vd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dd = d_seq[i];
            tick();
            check("t6_valid", 32'(ovd), 32'(i % 2 == 1));
            if (i == 1) check("t6_scale_pos", 32'(od), 32'(D_EXP_FIRST));
            if (i == 3) check("t6_scale_neg", 32'(od), 32'(D_EXP_SECOND));
        end
        vd = 1'b0;
        tick();
        check("t6_idle_valid", 32'(ovd), 32'd0);
        check("t6_idle_hold",  32'(hld), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
